uart_rx_frame: RTL and testbench

Parametrised UART receiver that replaces the fixed 8N1 receiver in the serial-control path. Supports 5–9 data bits, none/odd/even parity, one or two stop bits, and 3-sample majority voting per bit. Each frame is delivered through a held valid/ready handshake, with per-frame parity and framing error flags and an overrun pulse. It sits between the board `uart_rx` pin and the command/packet parser.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_frame.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, receiver FSM states, counter sizing.
`ifndef SYS_CLK_FREQ
`define SYS_CLK_FREQ 50000000
`endif
`ifndef UART_BPS
`define UART_BPS 115200
`endif
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Bits needed to count 0..cnt_max inclusive.
    function automatic int cnt_width(input int cnt_max);
        return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge detector.
module uart_rx_sync #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [1:0] sync_r;
    logic       prev_r;

    // Shift the pin through two flops, then remember the previous synced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {2{RESET_LEVEL}};
            prev_r <= RESET_LEVEL;
        end else begin
            sync_r <= {sync_r[0], din};
            prev_r <= sync_r[1];
        end
    end

    assign dout = sync_r[1];
    assign fall = prev_r & ~sync_r[1];

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// 3-sample majority voting, held valid/ready output with error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int      SYS_CLK_FREQ = `SYS_CLK_FREQ,
    parameter int      BPS          = `UART_BPS,
    parameter int      DATA_WIDTH   = `UART_DATA_WIDTH,
    parameter parity_e PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      CNT_CLK_MAX  = SYS_CLK_FREQ / BPS - 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  uart_rx_ready,
    output logic                  uart_rx_valid,
    output logic [DATA_WIDTH-1:0] uart_rx_data,
    output logic                  uart_rx_parity_err,
    output logic                  uart_rx_frame_err,
    output logic                  uart_rx_overrun
);

    localparam int            CW        = cnt_width(CNT_CLK_MAX);
    localparam int            HALF      = CNT_CLK_MAX / 2;
    localparam bit            PAR_EN    = (PARITY != PAR_NONE);
    localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_CLK_MAX);
    localparam logic [CW-1:0] SMP0_C    = CW'(HALF - 1);
    localparam logic [CW-1:0] SMP1_C    = CW'(HALF);
    localparam logic [CW-1:0] SMP2_C    = CW'(HALF + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_e             state_r;
    rx_state_e             state_nxt_s;
    logic [CW-1:0]         cnt_r;
    logic [3:0]            bit_idx_r;
    logic                  stop_idx_r;
    logic                  samp0_r;
    logic                  samp1_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_err_r;
    logic                  frm_err_r;
    logic                  rx_s;
    logic                  fall_s;
    logic                  bit_done_s;
    logic                  wrap_s;
    logic                  maj_s;
    logic                  par_exp_s;
    logic                  deliver_s;
    logic                  load_s;
    logic                  drop_s;

    uart_rx_sync #(
        .RESET_LEVEL (1'b1)
    ) u_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (uart_rx),
        .dout (rx_s),
        .fall (fall_s)
    );

    assign bit_done_s = (cnt_r == SMP2_C);
    assign wrap_s     = (cnt_r == CNT_MAX_C);
    // The third sample is the live line value at the decision point.
    assign maj_s      = (samp0_r & samp1_r) | (samp0_r & rx_s) | (samp1_r & rx_s);
    assign par_exp_s  = (PARITY == PAR_EVEN) ? (^shift_r) : ~(^shift_r);

    // FSM state register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (bit_done_s && maj_s) state_nxt_s = IDLE;
                else if (wrap_s)         state_nxt_s = DATA;
                else                     state_nxt_s = START;
            end
            DATA: begin
                if (wrap_s && (bit_idx_r == BIT_LAST)) begin
                    state_nxt_s = PAR_EN ? uart_pkg::PARITY : STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            uart_pkg::PARITY: begin
                if (wrap_s) state_nxt_s = STOP;
                else        state_nxt_s = uart_pkg::PARITY;
            end
            STOP: begin
                // Leave at the decision point so a following start edge is not missed.
                if (bit_done_s && (stop_idx_r == STOP_LAST)) state_nxt_s = IDLE;
                else                                          state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: frame completion and whether it can be handed over.
    always_comb begin
        deliver_s = 1'b0;
        load_s    = 1'b0;
        drop_s    = 1'b0;
        if ((state_r == STOP) && bit_done_s && (stop_idx_r == STOP_LAST)) begin
            deliver_s = 1'b1;
            load_s    = ~uart_rx_valid | uart_rx_ready;
            drop_s    = uart_rx_valid & ~uart_rx_ready;
        end else begin
            deliver_s = 1'b0;
        end
    end

    // Bit-period counter; held at zero while idle so each frame starts aligned.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((state_r == IDLE) || (state_nxt_s == IDLE) || wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Data-bit and stop-bit indices advance once per bit period.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
        end else begin
            if (state_r != DATA)  bit_idx_r <= 4'd0;
            else if (wrap_s)      bit_idx_r <= bit_idx_r + 4'd1;
            if (state_r != STOP)  stop_idx_r <= 1'b0;
            else if (wrap_s)      stop_idx_r <= 1'b1;
        end
    end

    // First two majority samples, taken around mid-bit.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            samp0_r <= 1'b1;
            samp1_r <= 1'b1;
        end else begin
            if (cnt_r == SMP0_C) samp0_r <= rx_s;
            if (cnt_r == SMP1_C) samp1_r <= rx_s;
        end
    end

    // Data shift register (LSB first) and per-frame error accumulation.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            shift_r   <= '0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            if ((state_r == DATA) && bit_done_s) begin
                shift_r <= {maj_s, shift_r[DATA_WIDTH-1:1]};
            end
            if (state_r == IDLE) begin
                par_err_r <= 1'b0;
                frm_err_r <= 1'b0;
            end else begin
                if ((state_r == uart_pkg::PARITY) && bit_done_s) begin
                    par_err_r <= PAR_EN & (maj_s != par_exp_s);
                end
                if ((state_r == STOP) && bit_done_s && !maj_s) begin
                    frm_err_r <= 1'b1;
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            uart_rx_valid      <= 1'b0;
            uart_rx_data       <= '0;
            uart_rx_parity_err <= 1'b0;
            uart_rx_frame_err  <= 1'b0;
            uart_rx_overrun    <= 1'b0;
        end else begin
            uart_rx_overrun <= drop_s;
            if (load_s) begin
                uart_rx_valid      <= 1'b1;
                uart_rx_data       <= shift_r;
                uart_rx_parity_err <= par_err_r;
                uart_rx_frame_err  <= frm_err_r | ~maj_s;
            end else if (uart_rx_valid && uart_rx_ready) begin
                uart_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8N2) driven at 50 MHz / 115200 baud.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int BIT    = CLK_HZ / BAUD;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [2:0] line  = 3'b111;
    logic [2:0] ready = 3'b111;
    wire  [2:0] valid;
    wire  [2:0] perr;
    wire  [2:0] ferr;
    wire  [2:0] ovr;
    wire  [2:0][7:0] data;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int total = 0;
    int bad   = 0;
    int ovr_cnt[3] = '{0, 0, 0};
    int vcyc[3]    = '{0, 0, 0};

    always #10 clk = ~clk;

    uart_rx_frame #(.SYS_CLK_FREQ(CLK_HZ), .BPS(BAUD), .DATA_WIDTH(8),
                    .PARITY(PAR_NONE), .STOP_BITS(1)) dut_n1 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[0]), .uart_rx_ready(ready[0]),
        .uart_rx_valid(valid[0]), .uart_rx_data(data[0]), .uart_rx_parity_err(perr[0]),
        .uart_rx_frame_err(ferr[0]), .uart_rx_overrun(ovr[0]));

    uart_rx_frame #(.SYS_CLK_FREQ(CLK_HZ), .BPS(BAUD), .DATA_WIDTH(8),
                    .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_e1 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[1]), .uart_rx_ready(ready[1]),
        .uart_rx_valid(valid[1]), .uart_rx_data(data[1]), .uart_rx_parity_err(perr[1]),
        .uart_rx_frame_err(ferr[1]), .uart_rx_overrun(ovr[1]));

    uart_rx_frame #(.SYS_CLK_FREQ(CLK_HZ), .BPS(BAUD), .DATA_WIDTH(8),
                    .PARITY(PAR_NONE), .STOP_BITS(2)) dut_n2 (
        .sys_clk(clk), .rst(rst), .uart_rx(line[2]), .uart_rx_ready(ready[2]),
        .uart_rx_valid(valid[2]), .uart_rx_data(data[2]), .uart_rx_parity_err(perr[2]),
        .uart_rx_frame_err(ferr[2]), .uart_rx_overrun(ovr[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard entry for instance i and compare it with the held frame.
    task automatic consume(input int i);
        exp_t e;
        bit   got;
        got = 1'b0;
        e   = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            default: got = 1'b0;
        endcase
        if (!got) begin
            check_val($sformatf("unexpected_frame_u%0d", i), 32'(data[i]), 32'hFFFF_FFFF);
        end else begin
            check_val($sformatf("data_u%0d", i), 32'(data[i]), 32'(e.d));
            check_val($sformatf("perr_u%0d", i), 32'(perr[i]), 32'(e.pe));
            check_val($sformatf("ferr_u%0d", i), 32'(ferr[i]), 32'(e.fe));
        end
    endtask

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                if (ovr[i])   ovr_cnt[i]++;
                if (valid[i]) vcyc[i]++;
                if (valid[i] && ready[i]) consume(i);
            end
        end
    end

    task automatic idle(input int idx, input int cycles);
        line[idx] = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drive one frame. pmode: 0 none, 1 odd, 2 even. pforce<0 computes parity.
    // stops[0]/stops[1] are stop-bit levels. Line keeps last bit level afterwards.
    task automatic send_frame(input int idx, input logic [7:0] d, input int pmode,
                              input int pforce, input int nstop, input logic [1:0] stops,
                              input bit push, input int spike_pos, input int abort_pos);
        logic [11:0] bits;
        logic        pb;
        logic        pgood;
        int          n;
        exp_t        e;
        pgood = (pmode == 2) ? (^d) : ~(^d);
        pb    = (pforce < 0) ? pgood : (pforce != 0);
        bits  = 12'd0;
        bits[8:1] = d;
        n = 9;
        if (pmode != 0) begin bits[n] = pb; n++; end
        bits[n] = stops[0]; n++;
        if (nstop == 2) begin bits[n] = stops[1]; n++; end
        e.d  = d;
        e.pe = (pmode != 0) && (pb != pgood);
        e.fe = !stops[0] || ((nstop == 2) && !stops[1]);
        if (push) begin
            case (idx)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < BIT; c++) begin
                @(negedge clk);
                if (p == abort_pos && c == 100) return;
                line[idx] = (p == spike_pos && c == 216) ? ~bits[p] : bits[p];
            end
        end
    endtask

    int v0;
    int o0;

    initial begin
        repeat (5) @(negedge clk);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_data",  32'(data), 32'd0);
        check_val("rst_flags", 32'({perr, ferr, ovr}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5 with ready high: exactly one valid cycle.
        v0 = vcyc[0];
        send_frame(0, 8'hA5, 0, -1, 1, 2'b11, 1'b1, -1, -1);
        idle(0, 20);
        check_val("a5_valid_cycles", 32'(vcyc[0] - v0), 32'd1);
        check_val("a5_delivered", 32'(q0.size()), 32'd0);

        // 8E1 0x3C with bad then good parity bit.
        send_frame(1, 8'h3C, 2, 1, 1, 2'b11, 1'b1, -1, -1);
        idle(1, 20);
        send_frame(1, 8'h3C, 2, 0, 1, 2'b11, 1'b1, -1, -1);
        idle(1, 20);
        check_val("e1_delivered", 32'(q1.size()), 32'd0);

        // 8N2 0x81 with second stop low, then 0x7E after half a bit of idle.
        send_frame(2, 8'h81, 0, -1, 2, 2'b01, 1'b1, -1, -1);
        idle(2, BIT / 2);
        send_frame(2, 8'h7E, 0, -1, 2, 2'b11, 1'b1, -1, -1);
        idle(2, 20);
        check_val("n2_delivered", 32'(q2.size()), 32'd0);

        // Short low glitch on idle line, then 0x55 with a 1-cycle spike in bit 0.
        v0 = vcyc[0];
        line[0] = 1'b0;
        repeat (100) @(negedge clk);
        idle(0, 1000);
        check_val("glitch_no_frame", 32'(vcyc[0] - v0), 32'd0);
        send_frame(0, 8'h55, 0, -1, 1, 2'b11, 1'b1, 1, -1);
        idle(0, 20);
        check_val("spike_delivered", 32'(q0.size()), 32'd0);

        // Break: all-zero with low stop, line held low afterwards.
        v0 = vcyc[0];
        send_frame(0, 8'h00, 0, -1, 1, 2'b00, 1'b1, -1, -1);
        repeat (3 * BIT) @(negedge clk);
        idle(0, BIT);
        check_val("break_one_frame", 32'(vcyc[0] - v0), 32'd1);
        check_val("break_delivered", 32'(q0.size()), 32'd0);

        // Back-pressure: 0x11 held, 0x22 dropped with one overrun pulse.
        ready[0] = 1'b0;
        o0 = ovr_cnt[0];
        send_frame(0, 8'h11, 0, -1, 1, 2'b11, 1'b1, -1, -1);
        idle(0, 50);
        send_frame(0, 8'h22, 0, -1, 1, 2'b11, 1'b0, -1, -1);
        idle(0, 50);
        check_val("ovr_pulses", 32'(ovr_cnt[0] - o0), 32'd1);
        check_val("held_valid", 32'(valid[0]), 32'd1);
        check_val("held_data", 32'(data[0]), 32'h11);
        @(posedge clk);
        #1 ready[0] = 1'b1;
        @(posedge clk);
        #1 check_val("valid_drop", 32'(valid[0]), 32'd0);
        check_val("held_consumed", 32'(q0.size()), 32'd0);
        @(negedge clk);

        // Reset in data bit 4 of 0x99, then 0x42.
        send_frame(0, 8'h99, 0, -1, 1, 2'b11, 1'b0, -1, 5);
        rst = 1'b1;
        line[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_val("midrst_valid", 32'(valid), 32'd0);
        check_val("midrst_data",  32'(data), 32'd0);
        check_val("midrst_flags", 32'({perr, ferr, ovr}), 32'd0);
        rst = 1'b0;
        v0 = vcyc[0];
        idle(0, 2 * BIT);
        check_val("aborted_no_frame", 32'(vcyc[0] - v0), 32'd0);
        send_frame(0, 8'h42, 0, -1, 1, 2'b11, 1'b1, -1, -1);
        idle(0, 20);
        check_val("post_rst_frames", 32'(vcyc[0] - v0), 32'd1);
        check_val("final_q0", 32'(q0.size()), 32'd0);
        check_val("final_q1", 32'(q1.size()), 32'd0);
        check_val("final_q2", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
